// File: rtl/video_tpg_axis_if.sv
// 24-bit AXI4-Stream video link: tuser marks start of frame, tlast marks end of line.
interface video_tpg_axis_if;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/video_tpg_axis.sv
// Test-pattern generator driving full AXI4-Stream video frames (bars, ramp, checkerboard, solid)
// with backpressure support, a frame-done pulse and a completed-frame counter.
module video_tpg_axis #(
    parameter int UDLY     = 1,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CHK_LOG2 = 5
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    enable,
    input  logic [1:0]              pattern_sel,
    input  logic [23:0]             solid_rgb,
    video_tpg_axis_if.master        m_axis_video,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt
);
    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);

    // Output delay applies in simulation only; the registers here are zero-delay.
    if (UDLY < 0) begin : g_udly_unused
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic [2:0]     bidx_q, bidx_d;
    logic [1:0]     pat_q, pat_d;
    logic [23:0]    solid_q, solid_d;
    logic [23:0]    tdata_q, tdata_d;
    logic           tvalid_q, tvalid_d;
    logic           tuser_q, tuser_d;
    logic           tlast_q, tlast_d;
    logic           done_q, done_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           hs, x_end, frame_end, load;

    // Bar index comes from the running bar counter, so no divider is needed.
    function automatic logic [23:0] pixel(input logic [1:0] p, input logic [23:0] s,
                                          input logic [XW-1:0] px, input logic [YW-1:0] py,
                                          input logic [2:0] bi);
        logic [31:0] xe;
        logic [31:0] ye;
        logic [23:0] v;
        xe = 32'(px);
        ye = 32'(py);
        case (p)
            2'd0: begin
                case (bi)
                    3'd0:    v = 24'hFFFFFF;
                    3'd1:    v = 24'hFF00FF;
                    3'd2:    v = 24'h00FFFF;
                    3'd3:    v = 24'h0000FF;
                    3'd4:    v = 24'hFFFF00;
                    3'd5:    v = 24'hFF0000;
                    3'd6:    v = 24'h00FF00;
                    default: v = 24'h000000;
                endcase
            end
            2'd1:    v = {3{xe[7:0]}};
            2'd2:    v = (xe[CHK_LOG2] ^ ye[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            default: v = s;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        bcnt_d    = bcnt_q;
        bidx_d    = bidx_q;
        pat_d     = pat_q;
        solid_d   = solid_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        load      = 1'b0;
        hs        = tvalid_q & m_axis_video.tready;
        x_end     = (x_q == X_LAST);
        frame_end = x_end && (y_q == Y_LAST);

        case (state_q)
            IDLE: begin
                if (enable) load = 1'b1;
            end
            ACTIVE: begin
                if (hs) begin
                    if (frame_end) begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                        if (enable) begin
                            load = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                            tuser_d  = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        if (x_end) begin
                            x_d    = '0;
                            y_d    = y_q + YW'(1);
                            bcnt_d = '0;
                            bidx_d = 3'd0;
                        end else begin
                            x_d = x_q + XW'(1);
                            if (bcnt_q == B_LAST) begin
                                bcnt_d = '0;
                                bidx_d = bidx_q + 3'd1;
                            end else begin
                                bcnt_d = bcnt_q + BW'(1);
                            end
                        end
                        tuser_d = 1'b0;
                        tlast_d = (x_d == X_LAST);
                        tdata_d = pixel(pat_q, solid_q, x_d, y_d, bidx_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: selection is captured here and held for the whole frame.
        if (load) begin
            state_d  = ACTIVE;
            pat_d    = pattern_sel;
            solid_d  = solid_rgb;
            x_d      = '0;
            y_d      = '0;
            bcnt_d   = '0;
            bidx_d   = 3'd0;
            tvalid_d = 1'b1;
            tuser_d  = 1'b1;
            tlast_d  = 1'b0;
            tdata_d  = pixel(pattern_sel, solid_rgb, '0, '0, 3'd0);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            bcnt_q   <= '0;
            bidx_q   <= 3'd0;
            pat_q    <= 2'd0;
            solid_q  <= 24'd0;
            tdata_q  <= 24'd0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bcnt_q   <= bcnt_d;
            bidx_q   <= bidx_d;
            pat_q    <= pat_d;
            solid_q  <= solid_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m_axis_video.tdata  = tdata_q;
    assign m_axis_video.tvalid = tvalid_q;
    assign m_axis_video.tuser  = tuser_q;
    assign m_axis_video.tlast  = tlast_q;
    assign frame_done          = done_q;
    assign frame_cnt           = cnt_q;
endmodule

// File: tb/tb_video_tpg_axis.sv
// Randomized bench for video_tpg_axis: every accepted beat is compared with a pixel model
// derived from coordinates, plus stall stability, frame gaps, counters and reset behaviour.
module tb_video_tpg_axis;
    localparam int H   = 16;
    localparam int V   = 4;
    localparam int CHK = 2;
    localparam int FB  = H * V;

    logic        aclk = 1'b0;
    logic        areset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic        frame_done;
    logic [15:0] frame_cnt;

    video_tpg_axis_if axis();

    video_tpg_axis #(.UDLY(1), .H_ACTIVE(H), .V_ACTIVE(V), .CHK_LOG2(CHK)) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .m_axis_video(axis), .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    always #5 aclk = ~aclk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [25:0] beat_q[$];
    int          cyc_q[$];
    logic        prev_stall = 1'b0;
    logic [25:0] prev_beat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Reference pixel straight from the pattern definitions, returned in {R,B,G} order.
    function automatic logic [23:0] pix_ref(input int pat, input logic [23:0] s, input int x, input int y);
        logic [23:0] rgb;
        logic [7:0]  g;
        case (pat)
            0: begin
                case (x / (H / 8))
                    0: rgb = 24'hFFFFFF; 1: rgb = 24'hFFFF00; 2: rgb = 24'h00FFFF; 3: rgb = 24'h00FF00;
                    4: rgb = 24'hFF00FF; 5: rgb = 24'hFF0000; 6: rgb = 24'h0000FF; default: rgb = 24'h000000;
                endcase
                return {rgb[23:16], rgb[7:0], rgb[15:8]};
            end
            1: begin
                g = 8'(x % 256);
                return {g, g, g};
            end
            2: return ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return s;
        endcase
    endfunction

    always @(posedge aclk) cyc++;

    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_stable", {5'd0, axis.tvalid, axis.tuser, axis.tlast, axis.tdata},
                    {5'd0, 1'b1, prev_beat});
            if (axis.tvalid && axis.tready) begin
                beat_q.push_back({axis.tuser, axis.tlast, axis.tdata});
                cyc_q.push_back(cyc);
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_beat  = {axis.tuser, axis.tlast, axis.tdata};
            if (frame_done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        enable = 1'b0;
        repeat (3) step();
        areset = 1'b0;
        beat_q.delete();
        cyc_q.delete();
        done_cnt = 0;
    endtask

    task automatic run_frames(input int nframes, input bit rnd, input int drop_at,
                              input int chg_at, input int budget);
        int c = 0;
        while (done_cnt < nframes && c < budget) begin
            axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (beat_q.size() >= drop_at) enable = 1'b0;
            if (beat_q.size() >= chg_at) begin
                pattern_sel = 2'd3;
                solid_rgb   = 24'h123456;
            end
            step();
            c++;
        end
        chk("frames_timeout", 32'(c < budget), 32'd1);
        enable      = 1'b0;
        axis.tready = 1'b1;
        repeat (3) step();
    endtask

    task automatic check_frame(input string tag, input int base, input int pat, input logic [23:0] s);
        for (int k = 0; k < FB; k++) begin
            if (base + k >= beat_q.size()) begin
                chk({tag, "_missing"}, 32'(base + k), 32'(beat_q.size()));
                return;
            end
            chk({tag, "_beat"}, 32'(beat_q[base + k]),
                32'({k == 0, (k % H) == H - 1, pix_ref(pat, s, k % H, k / H)}));
        end
    endtask

    initial begin
        int n;
        int p;
        logic [23:0] s;
        areset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 24'd0; axis.tready = 1'b1;
        do_reset();
        chk("rst_tvalid", 32'(axis.tvalid), 0);
        chk("rst_tuser", 32'(axis.tuser), 0);
        chk("rst_tlast", 32'(axis.tlast), 0);
        chk("rst_tdata", 32'(axis.tdata), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);

        // Single colour-bar frame with tready held high.
        pattern_sel = 2'd0;
        enable = 1'b1;
        chk("idle_tvalid", 32'(axis.tvalid), 0);
        step();
        chk("enable_latency", 32'(axis.tvalid), 1);
        run_frames(1, 1'b0, 1, 1 << 30, 2000);
        chk("bars_beats", 32'(beat_q.size()), FB);
        check_frame("bars", 0, 0, 24'd0);
        chk("bars_b2", 32'(beat_q[2][23:0]), 32'h00FF00FF);
        chk("bars_b14", 32'(beat_q[14][23:0]), 0);
        chk("bars_done_pulses", 32'(done_cnt), 1);
        chk("bars_cnt", 32'(frame_cnt), 1);
        chk("bars_idle", 32'(axis.tvalid), 0);

        // Ramp under random backpressure.
        do_reset();
        pattern_sel = 2'd1;
        enable = 1'b1;
        run_frames(1, 1'b1, 1, 1 << 30, 4000);
        chk("ramp_beats", 32'(beat_q.size()), FB);
        check_frame("ramp", 0, 1, 24'd0);
        chk("ramp_cnt", 32'(frame_cnt), 1);

        // Three back-to-back frames.
        do_reset();
        pattern_sel = 2'd1;
        enable = 1'b1;
        run_frames(3, 1'b0, 2 * FB + 1, 1 << 30, 4000);
        chk("cont_beats", 32'(beat_q.size()), 3 * FB);
        for (int f = 0; f < 3; f++) check_frame("cont", f * FB, 1, 24'd0);
        chk("cont_gap2", 32'(cyc_q[FB] - cyc_q[FB - 1]), 1);
        chk("cont_gap3", 32'(cyc_q[2 * FB] - cyc_q[2 * FB - 1]), 1);
        chk("cont_cnt", 32'(frame_cnt), 3);

        // Pattern change mid-frame applies only from the next frame.
        do_reset();
        pattern_sel = 2'd2;
        solid_rgb = 24'h000000;
        enable = 1'b1;
        run_frames(2, 1'b0, FB + 1, 10, 4000);
        chk("chg_beats", 32'(beat_q.size()), 2 * FB);
        check_frame("chg_chk", 0, 2, 24'd0);
        check_frame("chg_solid", FB, 3, 24'h123456);
        chk("chg_cnt", 32'(frame_cnt), 2);

        // Enable dropped mid-frame with random pattern: frame still completes.
        do_reset();
        p = int'($urandom_range(0, 3));
        s = 24'($urandom);
        pattern_sel = 2'(p);
        solid_rgb = s;
        enable = 1'b1;
        run_frames(1, 1'b0, 20, 1 << 30, 2000);
        chk("drop_beats", 32'(beat_q.size()), FB);
        check_frame("drop", 0, p, s);
        chk("drop_idle", 32'(axis.tvalid), 0);
        chk("drop_cnt", 32'(frame_cnt), 1);

        // Reset in the middle of a frame.
        do_reset();
        pattern_sel = 2'd0;
        enable = 1'b1;
        n = 0;
        while (beat_q.size() < 30 && n < 500) begin
            step();
            n++;
        end
        chk("rst_mid_timeout", 32'(n < 500), 1);
        areset = 1'b1;
        step();
        chk("rst_mid_tvalid", 32'(axis.tvalid), 0);
        chk("rst_mid_tlast", 32'(axis.tlast), 0);
        chk("rst_mid_cnt", 32'(frame_cnt), 0);
        n = 0;
        foreach (beat_q[i]) if (beat_q[i][24]) n++;
        chk("rst_mid_eols", 32'(n), 1);
        chk("rst_mid_done", 32'(done_cnt), 0);
        areset = 1'b0;
        beat_q.delete();
        cyc_q.delete();
        run_frames(1, 1'b0, 1, 1 << 30, 2000);
        check_frame("rst_after", 0, 0, 24'd0);
        chk("rst_after_cnt", 32'(frame_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
